output_forward: RTL and testbench
=================================

OUTPUT_FORWARD -- requirements
Module: output_forward

Interface
REQ-001 Parameter N_HIDDEN, default 4, number of hidden-neuron beats per forward pass; legal range 1..8.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous assert, active-low.
REQ-004 en_i  input  1  forward-pass enable from the state machine (f_pass); level-sensitive.
REQ-005 clear_i  input  1  synchronous clear of all datapath and control state.
REQ-006 hidden_val_i  input  10  unsigned hidden-neuron activation for the current beat.
REQ-007 w_i  input  8  unsigned output weight paired with hidden_val_i.
REQ-008 hidden_vld_i  input  1  beat valid; hidden_val_i and w_i stable while high.
REQ-009 hidden_rdy_o  output  1  block accepts a beat this cycle.
REQ-010 final_o  output  19  registered output-neuron value, consumed by backprop as final_i.
REQ-011 final_vld_o  output  1  final_o holds the result of a completed pass.
REQ-012 f_end_o  output  1  single-cycle pulse marking forward-pass completion.

Function
REQ-013 States: IDLE, ACCUM, DONE; the state register, 21-bit accumulator, 3-bit beat counter and all outputs are registered.
REQ-014 IDLE: hidden_rdy_o=0; en_i=1 -> ACCUM next cycle, accumulator and counter cleared to 0, final_vld_o cleared to 0.
REQ-015 ACCUM: hidden_rdy_o=1; a beat is accepted only when hidden_vld_i=1 and hidden_rdy_o=1; cycles with hidden_vld_i=0 change nothing.
REQ-016 Per accepted beat: 18-bit unsigned product hidden_val_i*w_i, zero-extended to 21 bits and added to the accumulator; counter increments by 1.
REQ-017 Accepting beat N_HIDDEN -> DONE next cycle; in that same edge final_o loads the converted sum (REQ-020/REQ-021); latency from last accepted beat to final_vld_o=1 is 1 cycle.
REQ-018 DONE: hidden_rdy_o=0, final_vld_o=1, final_o held; f_end_o=1 only in the first DONE cycle; en_i=0 -> IDLE; final_o keeps its value in IDLE until the next completed pass or a clear.
REQ-019 en_i=0 while in ACCUM: abort to IDLE next cycle; final_o and final_vld_o remain unchanged; no f_end_o; the partial sum is discarded.
REQ-020 Accumulator never wraps (max 8*1023*255 < 2^21).
REQ-021 Conversion to 19 bits is set by the Configuration section.
REQ-022 clear_i=1 (when not in reset): next cycle state IDLE, accumulator, counter, final_o, final_vld_o and f_end_o all 0; clear_i overrides en_i and beat acceptance.

Reset
REQ-023 rst_i=0 forces asynchronously: state IDLE, accumulator 0, counter 0, final_o 0, final_vld_o 0, f_end_o 0, hidden_rdy_o 0.
REQ-024 Reset asserted mid-pass abandons the pass; after release the block waits in IDLE for en_i.

Configuration
REQ-025 Macro OUTPUT_FORWARD_SAT_EN defined: final_o = min(accumulator, 19'h7FFFF) (unsigned saturation).
REQ-026 Macro OUTPUT_FORWARD_SAT_EN undefined: final_o = accumulator[18:0] (truncation, wrap modulo 2^19); all other behaviour identical.

Verification
REQ-027 Reset: hold rst_i=0 with random inputs -> all outputs 0; release -> hidden_rdy_o stays 0 until en_i=1.
REQ-028 Basic pass: en_i=1, 4 back-to-back beats of hidden=10, w=3 -> final_o=120, final_vld_o=1 and f_end_o=1 for 1 cycle, one cycle after the last beat.
REQ-029 Overflow: 4 beats of hidden=1023, w=255 (sum 1043460) -> final_o=524287 with OUTPUT_FORWARD_SAT_EN; 519172 without it.
REQ-030 Gapped valid: beats (5,2),(7,1),(1,100),(0,255) with idle cycles between them -> final_o=117; the idle cycles are not counted as beats.
REQ-031 Abort: complete a pass giving 120, start a new pass, drop en_i after 2 beats -> IDLE, final_o stays 120, final_vld_o=0, no f_end_o pulse.
REQ-032 Clear: clear_i=1 in DONE with en_i=1 -> next cycle state IDLE and final_o, final_vld_o, f_end_o all 0.

Source files
------------

// File: rtl/output_forward.sv
// Output-neuron forward pass: accumulates hidden*weight beats into a 19-bit result.
// Define OUTPUT_FORWARD_SAT_EN for unsigned saturation instead of truncation.
module output_forward #(
    parameter int N_HIDDEN = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clear_i,
    input  logic [9:0]  hidden_val_i,
    input  logic [7:0]  w_i,
    input  logic        hidden_vld_i,
    output logic        hidden_rdy_o,
    output logic [18:0] final_o,
    output logic        final_vld_o,
    output logic        f_end_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [20:0] acc;
    logic [2:0]  cnt;
    logic [17:0] prod;
    logic [20:0] sum_next;
    logic [18:0] conv;
    logic        accept;
    logic        last;

    assign prod     = {8'b0, hidden_val_i} * {10'b0, w_i};
    assign sum_next = acc + {3'b0, prod};
    assign last     = (cnt == 3'(N_HIDDEN - 1));
    // An abort (en_i low) takes priority over a beat presented in the same cycle
    assign accept   = (state == ACCUM) && en_i && hidden_vld_i && hidden_rdy_o;

`ifdef OUTPUT_FORWARD_SAT_EN
    assign conv = (sum_next > 21'h07FFFF) ? 19'h7FFFF : sum_next[18:0];
`else
    logic unused_hi;
    assign unused_hi = ^sum_next[20:19];
    assign conv      = sum_next[18:0];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            final_o      <= '0;
            final_vld_o  <= 1'b0;
            f_end_o      <= 1'b0;
            hidden_rdy_o <= 1'b0;
        end else if (clear_i) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            final_o      <= '0;
            final_vld_o  <= 1'b0;
            f_end_o      <= 1'b0;
            hidden_rdy_o <= 1'b0;
        end else begin
            f_end_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en_i) begin
                        state        <= ACCUM;
                        acc          <= '0;
                        cnt          <= '0;
                        final_vld_o  <= 1'b0;
                        hidden_rdy_o <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (!en_i) begin
                        state        <= IDLE;
                        hidden_rdy_o <= 1'b0;
                    end else if (accept) begin
                        acc <= sum_next;
                        cnt <= cnt + 3'd1;
                        if (last) begin
                            state        <= DONE;
                            final_o      <= conv;
                            final_vld_o  <= 1'b1;
                            f_end_o      <= 1'b1;
                            hidden_rdy_o <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!en_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    hidden_rdy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_forward.sv
// Randomised scoreboard bench for output_forward.
// Honours OUTPUT_FORWARD_SAT_EN the same way as the design build.
module tb_output_forward;

    localparam int NH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        clear_i;
    logic [9:0]  hidden_val_i;
    logic [7:0]  w_i;
    logic        hidden_vld_i;
    logic        hidden_rdy_o;
    logic [18:0] final_o;
    logic        final_vld_o;
    logic        f_end_o;

    output_forward #(.N_HIDDEN(NH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .clear_i      (clear_i),
        .hidden_val_i (hidden_val_i),
        .w_i          (w_i),
        .hidden_vld_i (hidden_vld_i),
        .hidden_rdy_o (hidden_rdy_o),
        .final_o      (final_o),
        .final_vld_o  (final_vld_o),
        .f_end_o      (f_end_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_final = 0;
    int   hv_a[8];
    int   w_a[8];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int conv(input int s);
`ifdef OUTPUT_FORWARD_SAT_EN
        return (s > 524287) ? 524287 : s;
`else
        return s % 524288;
`endif
    endfunction

    // Monitor: every f_end pulse must match the oldest expected pass
    initial begin : monitor
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (prev) chk("f_end_single", int'(f_end_o), 0);
            if (f_end_o) begin
                if (q.size() == 0) begin
                    chk("f_end_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("final_o", int'(final_o), e.val);
                    chk("final_vld_at_end", int'(final_vld_o), 1);
                    chk("end_cycle", cyc, e.cyc);
                end
            end
            prev = f_end_o;
        end
    end

    task automatic rand_data();
        hidden_val_i = 10'($urandom);
        w_i          = 8'($urandom);
    endtask

    task automatic run_pass(input int gmax, input int abort_at, input bit do_clear);
        int sum = 0;
        @(negedge clk_i);
        en_i = 1'b1;
        hidden_vld_i = 1'b0;
        @(negedge clk_i);
        chk("rdy_accum", int'(hidden_rdy_o), 1);
        for (int i = 0; i < NH; i++) begin
            if (i == abort_at) break;
            repeat ($urandom_range(0, gmax)) begin
                hidden_vld_i = 1'b0;
                rand_data();
                @(negedge clk_i);
            end
            hidden_vld_i = 1'b1;
            hidden_val_i = 10'(hv_a[i]);
            w_i          = 8'(w_a[i]);
            sum += hv_a[i] * w_a[i];
            if (i == NH - 1) begin
                exp_t e;
                e.val = conv(sum);
                e.cyc = cyc + 1;
                q.push_back(e);
            end
            @(negedge clk_i);
        end
        hidden_vld_i = 1'b0;
        if (abort_at >= 0 && abort_at < NH) begin
            en_i = 1'b0;
            @(negedge clk_i);
            chk("abort_rdy", int'(hidden_rdy_o), 0);
            chk("abort_vld", int'(final_vld_o), 0);
            chk("abort_final", int'(final_o), last_final);
            return;
        end
        last_final = conv(sum);
        chk("done_rdy", int'(hidden_rdy_o), 0);
        chk("done_vld", int'(final_vld_o), 1);
        if (do_clear) begin
            clear_i = 1'b1;
            @(negedge clk_i);
            clear_i = 1'b0;
            en_i = 1'b0;
            last_final = 0;
            chk("clr_final", int'(final_o), 0);
            chk("clr_vld", int'(final_vld_o), 0);
            chk("clr_fend", int'(f_end_o), 0);
            chk("clr_rdy", int'(hidden_rdy_o), 0);
            @(negedge clk_i);
            chk("clr_idle_rdy", int'(hidden_rdy_o), 0);
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        chk("done_hold", int'(final_o), last_final);
        en_i = 1'b0;
        @(negedge clk_i);
        chk("idle_rdy", int'(hidden_rdy_o), 0);
        chk("idle_hold", int'(final_o), last_final);
    endtask

    task automatic fill(input int h, input int w);
        for (int i = 0; i < 8; i++) begin
            hv_a[i] = h;
            w_a[i]  = w;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_i = 1'b0;
        en_i = 1'b0;
        clear_i = 1'b0;
        hidden_vld_i = 1'b0;
        rand_data();
        repeat (4) begin
            @(negedge clk_i);
            en_i = 1'($urandom);
            clear_i = 1'($urandom);
            hidden_vld_i = 1'($urandom);
            rand_data();
            #1;
            chk("rst_final", int'(final_o), 0);
            chk("rst_vld", int'(final_vld_o), 0);
            chk("rst_fend", int'(f_end_o), 0);
            chk("rst_rdy", int'(hidden_rdy_o), 0);
        end
        @(negedge clk_i);
        en_i = 1'b0;
        clear_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) begin
            hidden_vld_i = 1'($urandom);
            @(negedge clk_i);
            chk("post_rst_rdy", int'(hidden_rdy_o), 0);
        end
        hidden_vld_i = 1'b0;

        fill(10, 3);
        run_pass(0, -1, 1'b0);
        fill(1023, 255);
        run_pass(0, -1, 1'b0);
        hv_a[0] = 5; w_a[0] = 2;
        hv_a[1] = 7; w_a[1] = 1;
        hv_a[2] = 1; w_a[2] = 100;
        hv_a[3] = 0; w_a[3] = 255;
        run_pass(3, -1, 1'b0);
        chk("gapped_117", last_final, 117);
        fill(10, 3);
        run_pass(1, -1, 1'b0);
        run_pass(0, 2, 1'b0);
        chk("abort_keeps_120", int'(final_o), 120);
        run_pass(0, -1, 1'b1);

        // Reset asserted mid-pass abandons the partial sum
        fill(500, 200);
        @(negedge clk_i);
        en_i = 1'b1;
        @(negedge clk_i);
        hidden_vld_i = 1'b1;
        hidden_val_i = 10'd500;
        w_i = 8'd200;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("midrst_rdy", int'(hidden_rdy_o), 0);
        chk("midrst_final", int'(final_o), 0);
        hidden_vld_i = 1'b0;
        en_i = 1'b0;
        last_final = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
        fill(2, 2);
        run_pass(1, -1, 1'b0);

        for (int p = 0; p < 40; p++) begin
            int r;
            for (int i = 0; i < 8; i++) begin
                hv_a[i] = $urandom_range(0, 1023);
                w_a[i]  = $urandom_range(0, 255);
            end
            r = $urandom_range(0, 9);
            if (r < 2)
                run_pass(2, $urandom_range(0, NH - 1), 1'b0);
            else
                run_pass(2, -1, r == 2);
        end

        repeat (4) @(negedge clk_i);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
